// File: rtl/signed_mac_recomposer.sv
// Sequential signed multiply-add: result = Ain*Bin + Cin, one multiplier bit per cycle.
// Reconstructs a dividend from divider outputs (quotient, divisor, remainder).
module signed_mac_recomposer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     Ain,
    input  logic [WIDTH-1:0]     Bin,
    input  logic [2*WIDTH-1:0]   Cin,
    input  logic                 start,
    output logic                 MulWait,
    output logic                 writeResultSig,
    output logic [2*WIDTH-1:0]   result,
    output logic                 overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, mcand, cin_q, prod, sum;
    logic [WIDTH-1:0]   mplier, a_mag, b_mag;
    logic               sign;

    // Most negative operand negates to itself, which reads correctly as unsigned.
    assign a_mag = Ain[WIDTH-1] ? -Ain : Ain;
    assign b_mag = Bin[WIDTH-1] ? -Bin : Bin;
    assign prod  = sign ? -acc : acc;
    assign sum   = prod + cin_q;

    assign MulWait = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            acc            <= '0;
            mcand          <= '0;
            mplier         <= '0;
            cin_q          <= '0;
            sign           <= 1'b0;
            result         <= '0;
            overflow       <= 1'b0;
            writeResultSig <= 1'b0;
        end else begin
            writeResultSig <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cin_q  <= Cin;
                        sign   <= Ain[WIDTH-1] ^ Bin[WIDTH-1];
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH);
                    end
                end
                BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mplier <= mplier >> 1;
                    mcand  <= mcand << 1;
                    cnt    <= cnt - 1'b1;
                end
                DONE: begin
                    result         <= sum;
                    // Product always fits, so only the final add can overflow.
                    overflow       <= (prod[2*WIDTH-1] == cin_q[2*WIDTH-1]) &&
                                      (sum[2*WIDTH-1] != prod[2*WIDTH-1]);
                    writeResultSig <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_signed_mac_recomposer.sv
// Scoreboard bench: stimulus pushes integer-arithmetic expectations, a monitor checks each strobe.
module tb_signed_mac_recomposer;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   Ain = '0, Bin = '0;
    logic [2*W-1:0] Cin = '0;
    logic           start = 1'b0;
    logic           MulWait, writeResultSig, overflow;
    logic [2*W-1:0] result;

    signed_mac_recomposer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .Ain(Ain), .Bin(Bin), .Cin(Cin), .start(start),
        .MulWait(MulWait), .writeResultSig(writeResultSig), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] r;
        bit             ov;
        int             cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference: plain integer multiply-add, wrapped to 2W bits; overflow if out of signed range.
    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] c, input int at_cyc);
        exp_t e;
        int   s;
        s = int'($signed(a)) * int'($signed(b)) + int'($signed(c));
        e.r   = s[2*W-1:0];
        e.ov  = (s > 32767) || (s < -32768);
        e.cyc = at_cyc;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (writeResultSig) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", longint'(result), longint'(e.r));
                    chk("overflow", longint'(overflow), longint'(e.ov));
                    chk("latency", longint'(cyc), longint'(e.cyc + W + 1));
                    chk("mulwait_len", longint'(run), longint'(W + 1));
                    chk("mulwait_at_strobe", longint'(MulWait), 0);
                end
                run = 0;
            end else if (MulWait) run++;
            else run = 0;
        end
    end

    task automatic scramble();
        logic [31:0] r;
        r = $urandom;
        Ain = r[7:0];
        Bin = r[15:8];
        Cin = r[31:16];
    endtask

    // Launch one op; operands are scrambled right after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] c,
                         input bit record);
        @(negedge clk);
        Ain = a; Bin = b; Cin = c; start = 1'b1;
        @(posedge clk); #1;
        if (record) push_exp(a, b, c, cyc);
        start = 1'b0;
        scramble();
    endtask

    task automatic drain();
        repeat (W + 4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        bit          seen;

        repeat (3) @(negedge clk);
        chk("reset_mulwait", longint'(MulWait), 0);
        chk("reset_strobe", longint'(writeResultSig), 0);
        chk("reset_result", longint'(result), 0);
        chk("reset_overflow", longint'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(8'd2, 8'd40, 16'd10, 1); drain();
        issue(-8'sd7, 8'd13, 16'd0, 1); drain();
        issue(-8'sd7, -8'sd13, -16'sd1, 1); drain();
        issue(8'd0, -8'sd128, 16'd5, 1); drain();
        issue(-8'sd128, -8'sd128, 16'd0, 1); drain();
        issue(-8'sd128, 8'd127, 16'd0, 1); drain();
        issue(8'd127, 8'd127, 16'd32767, 1); drain();
        issue(8'd1, 8'd1, 16'd0, 1); drain();
        issue(8'd127, 8'd127, -16'sd32768, 1); drain();
        issue(-8'sd128, 8'd127, -16'sd32768, 1); drain();

        // start pulsed during BUSY is ignored
        issue(8'd25, -8'sd3, 16'd100, 1);
        repeat (2) @(negedge clk);
        Ain = 8'd99; Bin = 8'd99; Cin = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // start held through the strobe launches a second op with no gap
        @(negedge clk);
        Ain = 8'd17; Bin = -8'sd9; Cin = 16'd300; start = 1'b1;
        @(posedge clk); #1;
        push_exp(8'd17, -8'sd9, 16'd300, cyc);
        Ain = -8'sd50; Bin = 8'd77; Cin = -16'sd1000;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (writeResultSig) seen = 1;
        end
        chk("b2b_first_strobe_seen", longint'(seen), 1);
        @(posedge clk); #1;
        push_exp(-8'sd50, 8'd77, -16'sd1000, cyc);
        start = 1'b0;
        scramble();
        drain();

        // Asynchronous reset mid-BUSY discards the op
        issue(8'd11, 8'd12, 16'd13, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_mulwait", longint'(MulWait), 0);
        chk("rst_mid_strobe", longint'(writeResultSig), 0);
        chk("rst_mid_result", longint'(result), 0);
        chk("rst_mid_overflow", longint'(overflow), 0);
        #9 rst_n = 1'b1;
        drain(); drain();
        issue(-8'sd20, -8'sd20, 16'd7, 1); drain();

        // Random ops, some with start held back-to-back
        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            issue(r[7:0], r[15:8], {r[23:16], r[31:24]}, 1);
            if ((n % 4) != 3) drain();
            else repeat (W + 1) @(negedge clk);
        end
        drain();

        chk("queue_empty", longint'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
